// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator driven by a valid/ready command port.
// Latency: command accept at T -> AW/W or AR handshake at T+1, B/R at T+2, rsp_valid at T+3 (zero-wait slave).
// Backpressure: cmd_ready only in IDLE; rsp_* held until rsp_ready; AXI valids held until their handshake.
//
// Ports:
//   m1_axi_aclk / m1_axi_aresetn : clock, asynchronous active-low reset
//   cmd_*                        : command in (write flag, byte address, data, strobes)
//   rsp_*                        : result out (write echo, read data, captured BRESP/RRESP)
//   err_count                    : saturating count of SLVERR/DECERR responses
//   m1_axi_*                     : AXI4-Lite master channels AW, W, B, AR, R (all outputs registered)
module axi_lite_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                      m1_axi_aclk,
  input  logic                      m1_axi_aresetn,
  // command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [7:0]                err_count,
  // AXI4-Lite write address
  output logic [ADDR_WIDTH-1:0]     m1_axi_awaddr,
  output logic                      m1_axi_awvalid,
  input  logic                      m1_axi_awready,
  // AXI4-Lite write data
  output logic [DATA_WIDTH-1:0]     m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m1_axi_wstrb,
  output logic                      m1_axi_wvalid,
  input  logic                      m1_axi_wready,
  // AXI4-Lite write response
  input  logic [1:0]                m1_axi_bresp,
  input  logic                      m1_axi_bvalid,
  output logic                      m1_axi_bready,
  // AXI4-Lite read address
  output logic [ADDR_WIDTH-1:0]     m1_axi_araddr,
  output logic                      m1_axi_arvalid,
  input  logic                      m1_axi_arready,
  // AXI4-Lite read data
  input  logic [DATA_WIDTH-1:0]     m1_axi_rdata,
  input  logic [1:0]                m1_axi_rresp,
  input  logic                      m1_axi_rvalid,
  output logic                      m1_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                  state_q;
  logic                    cmd_ready_q;
  logic                    rsp_valid_q;
  logic                    rsp_write_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]              rsp_resp_q;
  logic [7:0]              err_count_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic                    awvalid_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    wvalid_q;
  logic                    bready_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic                    arvalid_q;
  logic                    rready_q;

  // cmd_ready is a register rather than a state decode so that every output,
  // including this one, reads 0 while reset is asserted. It rises one cycle
  // after reset release and one cycle after the response handshake.
  always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
    if (!m1_axi_aresetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      err_count_q <= 8'd0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            if (cmd_write) begin
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        WR: begin
          // A low valid in WR means that channel's handshake already happened,
          // so no separate "done" flags are needed.
          if (awvalid_q && m1_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m1_axi_wready)   wvalid_q  <= 1'b0;
          if ((!awvalid_q || m1_axi_awready) && (!wvalid_q || m1_axi_wready)) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m1_axi_bvalid && bready_q) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= m1_axi_bresp;
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            if (m1_axi_bresp[1] && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
            state_q     <= RSP;
          end
        end

        RD_ADDR: begin
          if (arvalid_q && m1_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (m1_axi_rvalid && rready_q) begin
            rready_q    <= 1'b0;
            rsp_resp_q  <= m1_axi_rresp;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= m1_axi_rdata;
            rsp_valid_q <= 1'b1;
            if (m1_axi_rresp[1] && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
            state_q     <= RSP;
          end
        end

        RSP: begin
          // cmd_ready rises only after this handshake, so a waiting command is
          // taken no earlier than the following cycle.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign err_count      = err_count_q;
  assign m1_axi_awaddr  = awaddr_q;
  assign m1_axi_awvalid = awvalid_q;
  assign m1_axi_wdata   = wdata_q;
  assign m1_axi_wstrb   = wstrb_q;
  assign m1_axi_wvalid  = wvalid_q;
  assign m1_axi_bready  = bready_q;
  assign m1_axi_araddr  = araddr_q;
  assign m1_axi_arvalid = arvalid_q;
  assign m1_axi_rready  = rready_q;

endmodule
